// File: rtl/jtag_boot_ctrl.sv
// JTAG boot sequencer: TAP reset, one IR load, one DR command shift, then
// releases the core via a sticky fetch-enable.
module jtag_boot_ctrl #(
  parameter int unsigned     CLK_DIV    = 4,
  parameter int unsigned     IR_W       = 4,
  parameter logic [IR_W-1:0] IR_VAL     = 4'h4,
  parameter int unsigned     DR_W       = 53,
  parameter int unsigned     TRST_TCKS  = 8,
  parameter bit              AUTO_START = 1'b1
) (
  input  logic            s_clk,
  input  logic            s_rst_n,
  input  logic            start_i,
  input  logic [DR_W-1:0] dr_i,
  input  logic            tdo_i,
  output logic            tck_o,
  output logic            trstn_o,
  output logic            tms_o,
  output logic            tdi_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            fetch_enable_o,
  output logic [DR_W-1:0] dr_capture_o
);

  // state    | meaning
  // IDLE     | tck parked low, waiting for start
  // TRST     | trstn low, tms high, TRST_TCKS periods
  // WALK_TLR | tms 1x5 then 0 -> Run-Test/Idle
  // WALK_IR  | tms 1,1,0,0 -> Shift-IR
  // SHIFT_IR | IR_VAL out LSB first, Exit1-IR on last bit
  // WALK_DR  | tms 1,1,0,0 -> Update-IR ... Shift-DR
  // SHIFT_DR | command word out, tdo captured, Exit1-DR on last bit
  // WALK_END | tms 1,0 -> Update-DR, Run-Test/Idle
  // DONE     | one-cycle done pulse, fetch-enable set
  typedef enum logic [3:0] {
    IDLE, TRST, WALK_TLR, WALK_IR, SHIFT_IR, WALK_DR, SHIFT_DR, WALK_END, DONE
  } state_t;

  localparam int unsigned LEN_A   = (DR_W > IR_W) ? DR_W : IR_W;
  localparam int unsigned LEN_B   = (LEN_A > TRST_TCKS) ? LEN_A : TRST_TCKS;
  localparam int unsigned MAX_LEN = (LEN_B > 6) ? LEN_B : 6;
  localparam int unsigned STEP_W  = $clog2(MAX_LEN);
  localparam int unsigned PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t            state, adv_state;
  logic [STEP_W-1:0] step, adv_step;
  logic [PH_W-1:0]   phase;
  logic [DR_W-1:0]   dr_q;
  logic              auto_pend;
  logic              nxt_tms, nxt_tdi;
  logic              phase_last;

  function automatic logic [STEP_W-1:0] last_step(input state_t s);
    case (s)
      TRST:             last_step = STEP_W'(TRST_TCKS - 1);
      WALK_TLR:         last_step = STEP_W'(5);
      WALK_IR, WALK_DR: last_step = STEP_W'(3);
      SHIFT_IR:         last_step = STEP_W'(IR_W - 1);
      SHIFT_DR:         last_step = STEP_W'(DR_W - 1);
      WALK_END:         last_step = STEP_W'(1);
      default:          last_step = '0;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s);
    case (s)
      TRST:     next_state = WALK_TLR;
      WALK_TLR: next_state = WALK_IR;
      WALK_IR:  next_state = SHIFT_IR;
      SHIFT_IR: next_state = WALK_DR;
      WALK_DR:  next_state = SHIFT_DR;
      SHIFT_DR: next_state = WALK_END;
      WALK_END: next_state = DONE;
      default:  next_state = IDLE;
    endcase
  endfunction

  assign phase_last = (phase == PH_W'(CLK_DIV - 1));

  // Pins for the tck period that begins at the next falling edge (or at start).
  always_comb begin
    adv_state = state;
    adv_step  = step + 1'b1;
    if (state == IDLE) begin
      adv_state = TRST;
      adv_step  = '0;
    end else if (step == last_step(state)) begin
      adv_state = next_state(state);
      adv_step  = '0;
    end
    nxt_tms = 1'b0;
    nxt_tdi = 1'b0;
    case (adv_state)
      TRST:             nxt_tms = 1'b1;
      WALK_TLR:         nxt_tms = (adv_step < STEP_W'(5));
      WALK_IR, WALK_DR: nxt_tms = (adv_step < STEP_W'(2));
      SHIFT_IR: begin
        nxt_tms = (adv_step == last_step(SHIFT_IR));
        nxt_tdi = |(IR_VAL & (IR_W'(1) << adv_step));
      end
      SHIFT_DR: begin
        nxt_tms = (adv_step == last_step(SHIFT_DR));
        nxt_tdi = |(dr_q & (DR_W'(1) << adv_step));
      end
      WALK_END:         nxt_tms = (adv_step == '0);
      default:          ;
    endcase
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state          <= IDLE;
      step           <= '0;
      phase          <= '0;
      dr_q           <= '0;
      auto_pend      <= AUTO_START;
      tck_o          <= 1'b0;
      trstn_o        <= 1'b0;
      tms_o          <= 1'b1;
      tdi_o          <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      fetch_enable_o <= 1'b0;
      dr_capture_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          trstn_o <= 1'b1;
          if (start_i || auto_pend) begin
            auto_pend    <= 1'b0;
            dr_q         <= dr_i;
            dr_capture_o <= '0;
            busy_o       <= 1'b1;
            state        <= adv_state;
            step         <= adv_step;
            phase        <= '0;
            tck_o        <= 1'b0;
            trstn_o      <= 1'b0;
            tms_o        <= nxt_tms;
            tdi_o        <= nxt_tdi;
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (phase_last) begin
            phase <= '0;
            tck_o <= ~tck_o;
            if (!tck_o) begin
              if (state == SHIFT_DR)
                dr_capture_o <= dr_capture_o | (DR_W'(tdo_i) << step);
            end else begin
              state   <= adv_state;
              step    <= adv_step;
              tms_o   <= nxt_tms;
              tdi_o   <= nxt_tdi;
              trstn_o <= (adv_state != TRST);
              if (adv_state == DONE) begin
                done_o         <= 1'b1;
                busy_o         <= 1'b0;
                fetch_enable_o <= 1'b1;
              end
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_boot_ctrl.sv
// Bench for jtag_boot_ctrl: behavioural TAP model plus a done-triggered
// scoreboard holding per-sequence expectations.
module tb_jtag_boot_ctrl;

  localparam int DR_W = 53;
  localparam logic [52:0] DR1  = 53'h1A10_7008_5;
  localparam logic [52:0] DR2  = 53'h1F_0000_FFFF_0001;
  localparam logic [52:0] DR3  = 53'h0_DEAD_BEEF_CAFE;
  localparam logic [52:0] PAT1 = 53'h0_AAAA_5555_1234;
  localparam logic [52:0] PAT2 = 53'h15_5555_0F0F_3C3C;
  localparam logic [52:0] JUNK = 53'h1F_FFFF_FFFF_FFFF;

  logic             s_clk = 1'b0;
  logic             s_rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [DR_W-1:0]  dr_i = '0;
  logic             tdo_i;
  logic             tck_o, trstn_o, tms_o, tdi_o, busy_o, done_o, fetch_enable_o;
  logic [DR_W-1:0]  dr_capture_o;

  jtag_boot_ctrl #(
    .CLK_DIV(4), .IR_W(4), .IR_VAL(4'h4), .DR_W(DR_W), .TRST_TCKS(8), .AUTO_START(1'b1)
  ) dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .start_i(start_i), .dr_i(dr_i), .tdo_i(tdo_i),
    .tck_o(tck_o), .trstn_o(trstn_o), .tms_o(tms_o), .tdi_o(tdi_o), .busy_o(busy_o),
    .done_o(done_o), .fetch_enable_o(fetch_enable_o), .dr_capture_o(dr_capture_o)
  );

  always #5 s_clk = ~s_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- TAP model ----------------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  tap_t        tap = TLR;
  logic [3:0]  ir_sr = '0, tap_ir = '1;
  logic [52:0] dr_sr = '0, tap_dr = '0;
  logic [5:0]  dr_bit = '0;
  logic [52:0] tdo_pat = '0;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:   return tms ? TLR   : RTI;
      RTI:   return tms ? SELDR : RTI;
      SELDR: return tms ? SELIR : CAPDR;
      CAPDR: return tms ? EX1DR : SHDR;
      SHDR:  return tms ? EX1DR : SHDR;
      EX1DR: return tms ? UPDR  : PADR;
      PADR:  return tms ? EX2DR : PADR;
      EX2DR: return tms ? UPDR  : SHDR;
      UPDR:  return tms ? SELDR : RTI;
      SELIR: return tms ? TLR   : CAPIR;
      CAPIR: return tms ? EX1IR : SHIR;
      SHIR:  return tms ? EX1IR : SHIR;
      EX1IR: return tms ? UPIR  : PAIR;
      PAIR:  return tms ? EX2IR : PAIR;
      EX2IR: return tms ? UPIR  : SHIR;
      default: return tms ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck_o or negedge trstn_o) begin
    if (!trstn_o) begin
      tap    = TLR;
      tap_ir = '1;
      tap_dr = '0;
      dr_bit = '0;
    end else begin
      if (tap == SHIR) ir_sr = {tdi_o, ir_sr[3:1]};
      if (tap == SHDR) begin
        dr_sr  = {tdi_o, dr_sr[52:1]};
        dr_bit = dr_bit + 1'b1;
      end
      if (tap == CAPDR) dr_bit = '0;
      tap = tap_next(tap, tms_o);
      if (tap == UPIR) tap_ir = ir_sr;
      if (tap == UPDR) tap_dr = dr_sr;
    end
  end

  assign tdo_i = (tap == SHDR) ? tdo_pat[dr_bit] : 1'b0;

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [52:0] dr;
    logic [52:0] cap;
    logic        fe_during;
  } exp_t;
  exp_t exp_q[$];

  int   edges = 0, busy_cyc = 0, stab_err = 0, done_cnt = 0;
  logic fe_any = 1'b0, fe_all = 1'b1;
  logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0, p_trstn = 1'b0;

  always @(negedge s_clk) begin
    exp_t e;
    if (!s_rst_n) begin
      edges = 0; busy_cyc = 0; stab_err = 0; fe_any = 1'b0; fe_all = 1'b1;
    end else begin
      if (tck_o && !p_tck) edges++;
      if (tck_o && (tms_o !== p_tms || tdi_o !== p_tdi || trstn_o !== p_trstn)) stab_err++;
      if (busy_o) begin
        busy_cyc++;
        fe_any = fe_any | fetch_enable_o;
        fe_all = fe_all & fetch_enable_o;
      end
      if (done_o) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done pulse %0d, expected none", done_cnt);
        end else begin
          e = exp_q.pop_front();
          check("dr_capture", 64'(dr_capture_o), 64'(e.cap));
          check("tap_ir_update", 64'(tap_ir), 64'h4);
          check("tap_dr_update", 64'(tap_dr), 64'(e.dr));
          check("tap_final_rti", 64'(tap), 64'(RTI));
          check("tck_rises", 64'(edges), 64'd81);
          check("busy_cycles_in_range", 64'(busy_cyc >= 644 && busy_cyc <= 652), 64'd1);
          check("busy_low_at_done", 64'(busy_o), 64'd0);
          check("fetch_en_at_done", 64'(fetch_enable_o), 64'd1);
          check("tck_low_at_done", 64'(tck_o), 64'd0);
          check("pins_stable_tck_high", 64'(stab_err), 64'd0);
          if (e.fe_during) check("fetch_en_held", 64'(fe_all), 64'd1);
          else             check("fetch_en_low_while_busy", 64'(fe_any), 64'd0);
        end
        edges = 0; busy_cyc = 0; stab_err = 0; fe_any = 1'b0; fe_all = 1'b1;
      end
    end
    p_tck = tck_o; p_tms = tms_o; p_tdi = tdi_o; p_trstn = trstn_o;
  end

  // ---------------- stimulus ----------------
  task automatic push_exp(input logic [52:0] dr, input logic [52:0] cap, input logic fe);
    exp_t e;
    e.dr = dr; e.cap = cap; e.fe_during = fe;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tck"},   64'(tck_o), 64'd0);
    check({tag, "_trstn"}, 64'(trstn_o), 64'd0);
    check({tag, "_tms"},   64'(tms_o), 64'd1);
    check({tag, "_tdi"},   64'(tdi_o), 64'd0);
    check({tag, "_busy"},  64'(busy_o), 64'd0);
    check({tag, "_done"},  64'(done_o), 64'd0);
    check({tag, "_fe"},    64'(fetch_enable_o), 64'd0);
    check({tag, "_cap"},   64'(dr_capture_o), 64'd0);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge s_clk); #1; n++;
    end
    check("sequence_completes", 64'(done_cnt), 64'(target));
  endtask

  task automatic pulse_start();
    @(negedge s_clk); start_i = 1'b1;
    @(negedge s_clk); start_i = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    repeat (3) @(negedge s_clk);
    check_reset("reset");

    // sequence 1: auto-start on reset release
    dr_i = DR1; tdo_pat = PAT1;
    push_exp(DR1, PAT1, 1'b0);
    s_rst_n = 1'b1;
    @(posedge s_clk); #1;
    check("busy_after_start", 64'(busy_o), 64'd1);
    check("trstn_low_in_trst", 64'(trstn_o), 64'd0);
    dr_i = JUNK;
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(posedge s_clk); #1;
      if (tck_o && lat == 0) lat = i;
    end
    check("first_tck_rise_latency", 64'(lat), 64'd5);
    wait_done(1, 2000);
    repeat (50) @(negedge s_clk);
    check("idle_after_seq1_busy", 64'(busy_o), 64'd0);
    check("idle_after_seq1_fe", 64'(fetch_enable_o), 64'd1);
    check("idle_trstn_high", 64'(trstn_o), 64'd1);

    // sequence 2: explicit start, extra starts during busy and DONE ignored
    dr_i = DR2; tdo_pat = PAT2;
    push_exp(DR2, PAT2, 1'b1);
    pulse_start();
    dr_i = JUNK;
    repeat (100) @(negedge s_clk);
    pulse_start();
    repeat (200) @(negedge s_clk);
    pulse_start();
    n = 0;
    while (!done_o && n < 2000) begin
      @(negedge s_clk); #1; n++;
    end
    check("done_seen_for_start_in_done", 64'(done_o), 64'd1);
    start_i = 1'b1;
    @(posedge s_clk); #1;
    start_i = 1'b0;
    repeat (100) @(negedge s_clk);
    check("no_restart_busy", 64'(busy_o), 64'd0);
    check("no_restart_done_count", 64'(done_cnt), 64'd2);

    // sequence 3: aborted by reset mid Shift-DR, then auto-restart
    dr_i = DR3; tdo_pat = PAT1;
    pulse_start();
    n = 0;
    while (!(tap == SHDR && dr_bit == 6'd20) && n < 3000) begin
      @(negedge s_clk); n++;
    end
    check("reached_shift_dr", 64'(tap == SHDR), 64'd1);
    #2 s_rst_n = 1'b0;
    #1 check_reset("midreset");
    repeat (3) @(negedge s_clk);
    dr_i = DR3; tdo_pat = PAT2;
    push_exp(DR3, PAT2, 1'b0);
    s_rst_n = 1'b1;
    wait_done(3, 2000);

    repeat (50) @(negedge s_clk);
    check("final_done_count", 64'(done_cnt), 64'd3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(busy_o), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run so far", tests);
    $fatal(1, "watchdog");
  end

endmodule
